// File: rtl/sysbus_mem_responder_if.sv
// Sysbus request/response bundle between a line initiator (core fetch/memory
// side) and a memory responder.
//   reqcyc  : initiator request / write-data valid
//   req     : request address (first cycle) or write data beat
//   reqtag  : request tag, [TAG_W-1]=1 READ / 0 WRITE, [11:8] target, [7:0] id
//   reqack  : responder accepted the request or write beat (one-cycle pulse)
//   respcyc : read response beat valid
//   resp    : read response data
//   resptag : tag echoed from the accepted request
//   respack : initiator accepts the current response beat
interface sysbus_mem_responder_if #(
  parameter int TAG_W = 13
);
  logic             reqcyc;
  logic [63:0]      req;
  logic [TAG_W-1:0] reqtag;
  logic             reqack;
  logic             respcyc;
  logic [63:0]      resp;
  logic [TAG_W-1:0] resptag;
  logic             respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Memory-side responder of the Sysbus line protocol, usable as the simulation
// memory model. One line request is handled at a time: the request is acked,
// then a read streams 8 x 64-bit beats (starting at the requested word and
// wrapping inside the 64-byte line) after LATENCY idle cycles, or a write
// absorbs 8 data beats into the backing store.
// Ports:
//   clk   : bus clock, all state on posedge
//   reset : synchronous, active-high; aborts any transfer, store untouched
//   bus   : Sysbus slave modport (reqcyc/req/reqtag/reqack, respcyc/resp/
//           resptag/respack)
module sysbus_mem_responder #(
  parameter int MEM_WORDS = 1 << 20,
  parameter int LATENCY   = 4,
  parameter int TAG_W     = 13
) (
  input logic                   clk,
  input logic                   reset,
  sysbus_mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_WAIT,
    ST_RESP,
    ST_WDATA
  } state_t;

  state_t           state_q, state_d;
  logic [57:0]      line_q, line_d;
  logic [2:0]       word_q, word_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [2:0]       beat_q, beat_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic             rd_oor_q;
  logic [63:0]      rd_data_q;

  logic [63:0]      mem_q [MEM_WORDS];

  logic [2:0]       acc_beat;
  logic [2:0]       acc_wrd;
  logic [60:0]      acc_word;
  logic [IDX_W-1:0] acc_idx;
  logic             acc_oor;
  logic             rd_en;
  logic             wr_en;

  // Byte offset within a 64-bit word carries no meaning for this bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req[2:0];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      line_q   <= '0;
      word_q   <= '0;
      tag_q    <= '0;
      beat_q   <= '0;
      lat_q    <= '0;
      rd_oor_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      word_q   <= word_d;
      tag_q    <= tag_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      if (rd_en) begin
        rd_oor_q <= acc_oor;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    word_d  = word_q;
    tag_d   = tag_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.reqcyc) begin
          line_d  = bus.req[63:6];
          word_d  = bus.req[5:3];
          tag_d   = bus.reqtag;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        beat_d = '0;
        if (tag_q[TAG_W-1]) begin
          lat_d   = LAT_INIT;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_WDATA;
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          state_d = ST_RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.respack) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == 3'd7) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WDATA: begin
        if (bus.reqcyc) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == 3'd7) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store access. The read port is registered, so the word for the next beat
  // is fetched one cycle ahead: the last WAIT cycle fetches beat 0 and every
  // accepted RESP beat fetches the following one. Holding rd_data_q between
  // fetches keeps resp stable under backpressure.
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_beat = (state_q == ST_RESP) ? beat_q + 1'b1 : beat_q;
  end

  assign acc_wrd  = word_q + acc_beat;      // wraps within the line
  assign acc_word = {line_q, acc_wrd};
  assign acc_idx  = acc_word[IDX_W-1:0];
  assign acc_oor  = |acc_word[60:IDX_W];

  assign rd_en = ((state_q == ST_WAIT) && (lat_q == '0)) ||
                 ((state_q == ST_RESP) && bus.respack);
  assign wr_en = (state_q == ST_WDATA) && bus.reqcyc && !acc_oor && !reset;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[acc_idx] <= bus.req;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[acc_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.reqack  = 1'b0;
    bus.respcyc = 1'b0;
    bus.resp    = '0;
    bus.resptag = tag_q;
    case (state_q)
      ST_ACK:   bus.reqack = 1'b1;
      ST_WDATA: bus.reqack = bus.reqcyc;  // beat accepted in the same cycle
      ST_RESP: begin
        bus.respcyc = 1'b1;
        // Words beyond the store read as zero.
        bus.resp    = rd_oor_q ? 64'd0 : rd_data_q;
      end
      default: ;
    endcase
  end

endmodule
